// File: rtl/dmem_trace_pkg.sv
// Shared types and constants for the data-memory write tracer.
// Optional timestamp field is enabled by defining DMEM_TRACE_TIMESTAMP_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package dmem_trace_pkg;
   localparam int TS_W       = 32;
   localparam int TRC_ADDR_W = `ADDR_WIDTH;
   localparam int TRC_DATA_W = 16;

   // Default-width entry layout, as seen by debug readout decoders.
   typedef struct packed {
      logic [TRC_ADDR_W-1:0] addr;
      logic [TRC_DATA_W-1:0] data;
      logic                  byt;
`ifdef DMEM_TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]       ts;
`endif
   } trace_entry_t;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with flush; head is always on rdata.
// Pointers carry one extra wrap bit so full/empty come from the MSB comparison.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             empty, pop_acc, push_acc;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign valid    = ~empty;
   assign count    = wr_ptr - rd_ptr;
   assign pop_acc  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_acc = push & (~full | pop_acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/dmem_write_tracer.sv
// Snoops CPU data-memory writes into a filtered FWFT trace FIFO with drop counter.
// Define DMEM_TRACE_TIMESTAMP_EN to add a 32-bit capture timestamp (trc_ts).
module dmem_write_tracer
   import dmem_trace_pkg::*;
#(
   parameter int ADDR_W = `ADDR_WIDTH,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int DROP_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dmem_wen,
   input  logic                   dmem_byt,
   input  logic [ADDR_W-1:0]      dmem_addr,
   input  logic [DATA_W-1:0]      dmem_wdata,
   input  logic                   trc_en,
   input  logic [ADDR_W-1:0]      win_lo,
   input  logic [ADDR_W-1:0]      win_hi,
   input  logic                   trc_clr,
   input  logic                   trc_pop,
   output logic                   trc_valid,
   output logic [ADDR_W-1:0]      trc_addr,
   output logic [DATA_W-1:0]      trc_data,
   output logic                   trc_byt,
   output logic [$clog2(DEPTH):0] trc_count,
   output logic                   trc_full,
   output logic [DROP_W-1:0]      drop_cnt,
   output logic [ADDR_W-1:0]      last_wr_addr,
   output logic [DATA_W-1:0]      last_wr_data
`ifdef DMEM_TRACE_TIMESTAMP_EN
   ,
   output logic [TS_W-1:0]        trc_ts
`endif
);
   // Same layout as trace_entry_t, at this instance's parameter widths.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              byt;
`ifdef DMEM_TRACE_TIMESTAMP_EN
      logic [TS_W-1:0]   ts;
`endif
   } entry_t;

   entry_t wr_entry, rd_entry;
   logic   push_req, pop_acc, drop_evt;

   assign push_req = dmem_wen & trc_en & (dmem_addr >= win_lo) & (dmem_addr <= win_hi);
   assign pop_acc  = trc_pop & trc_valid;
   assign drop_evt = push_req & trc_full & ~pop_acc & ~trc_clr;

`ifdef DMEM_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_cnt <= '0;
      else     ts_cnt <= ts_cnt + 1'b1;
   end

   assign wr_entry = '{addr: dmem_addr, data: dmem_wdata, byt: dmem_byt, ts: ts_cnt};
   assign trc_ts   = rd_entry.ts;
`else
   assign wr_entry = '{addr: dmem_addr, data: dmem_wdata, byt: dmem_byt};
`endif

   sync_fifo_fwft #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (trc_clr),
      .push  (push_req),
      .pop   (trc_pop),
      .wdata (wr_entry),
      .rdata (rd_entry),
      .valid (trc_valid),
      .full  (trc_full),
      .count (trc_count)
   );

   assign trc_addr = rd_entry.addr;
   assign trc_data = rd_entry.data;
   assign trc_byt  = rd_entry.byt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             drop_cnt <= '0;
      else if (trc_clr)                    drop_cnt <= '0;
      else if (drop_evt && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
   end

   // Legacy last-write capture ignores enable, window and flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_wr_addr <= '0;
         last_wr_data <= '1;
      end else if (dmem_wen) begin
         last_wr_addr <= dmem_addr;
         last_wr_data <= dmem_wdata;
      end
   end
endmodule

// File: tb/tb_dmem_write_tracer.sv
// Directed bench for dmem_write_tracer (DEPTH=4, DROP_W=3) with an expected-entry queue.
module tb_dmem_write_tracer;
   logic        clk = 1'b0;
   logic        rst;
   logic        dmem_wen, dmem_byt, trc_en, trc_clr, trc_pop;
   logic [15:0] dmem_addr, dmem_wdata, win_lo, win_hi;
   logic        trc_valid, trc_byt, trc_full;
   logic [15:0] trc_addr, trc_data, last_wr_addr, last_wr_data;
   logic [2:0]  trc_count;
   logic [2:0]  drop_cnt;
`ifdef DMEM_TRACE_TIMESTAMP_EN
   logic [31:0] trc_ts;
`endif

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q[$];
   logic [2:0]  exp_drop;
   logic [15:0] exp_laddr, exp_ldata;

   always #5 clk = ~clk;

   dmem_write_tracer #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .DROP_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .dmem_wen     (dmem_wen),
      .dmem_byt     (dmem_byt),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .trc_en       (trc_en),
      .win_lo       (win_lo),
      .win_hi       (win_hi),
      .trc_clr      (trc_clr),
      .trc_pop      (trc_pop),
      .trc_valid    (trc_valid),
      .trc_addr     (trc_addr),
      .trc_data     (trc_data),
      .trc_byt      (trc_byt),
      .trc_count    (trc_count),
      .trc_full     (trc_full),
      .drop_cnt     (drop_cnt),
      .last_wr_addr (last_wr_addr),
      .last_wr_data (last_wr_data)
`ifdef DMEM_TRACE_TIMESTAMP_EN
      ,
      .trc_ts       (trc_ts)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("count", {29'd0, trc_count}, exp_q.size());
      chk("drop_cnt", {29'd0, drop_cnt}, {29'd0, exp_drop});
      chk("valid", {31'd0, trc_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
      chk("full", {31'd0, trc_full}, (exp_q.size() == 4) ? 32'd1 : 32'd0);
      chk("last_wr_addr", {16'd0, last_wr_addr}, {16'd0, exp_laddr});
      chk("last_wr_data", {16'd0, last_wr_data}, {16'd0, exp_ldata});
      if (exp_q.size() > 0) begin
         chk("head_addr", {16'd0, trc_addr}, {16'd0, exp_q[0][32:17]});
         chk("head_data", {16'd0, trc_data}, {16'd0, exp_q[0][16:1]});
         chk("head_byt", {31'd0, trc_byt}, {31'd0, exp_q[0][0]});
      end else begin
         chk("empty_addr", {16'd0, trc_addr}, 32'd0);
         chk("empty_data", {16'd0, trc_data}, 32'd0);
      end
   endtask

   // One clock cycle of stimulus: drive at negedge, update model, check at next negedge.
   task automatic step(input logic wen, input logic byt, input logic [15:0] addr,
                       input logic [15:0] data, input logic pop, input logic clr);
      logic qual, pop_acc;
      dmem_wen = wen; dmem_byt = byt; dmem_addr = addr; dmem_wdata = data;
      trc_pop = pop; trc_clr = clr;
      qual = wen & trc_en & (addr >= win_lo) & (addr <= win_hi);
      if (wen) begin
         exp_laddr = addr;
         exp_ldata = data;
      end
      if (clr) begin
         exp_q.delete();
         exp_drop = 3'd0;
      end else begin
         pop_acc = pop && (exp_q.size() > 0);
         if (pop_acc) void'(exp_q.pop_front());
         if (qual) begin
            if (exp_q.size() < 4) exp_q.push_back({addr, data, byt});
            else if (exp_drop != 3'd7) exp_drop++;
         end
      end
      @(negedge clk);
      dmem_wen = 1'b0; trc_pop = 1'b0; trc_clr = 1'b0;
      chk_state();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic write(input logic [15:0] addr, input logic [15:0] data, input logic byt);
      step(1'b1, byt, addr, data, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_drop  = 3'd0;
      exp_laddr = 16'h0000;
      exp_ldata = 16'hFFFF;
   endtask

   initial begin
      rst = 1'b1;
      dmem_wen = 1'b0; dmem_byt = 1'b0; dmem_addr = '0; dmem_wdata = '0;
      trc_en = 1'b1; win_lo = 16'h0000; win_hi = 16'hFFFF; trc_clr = 1'b0; trc_pop = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_state();

      // First capture and legacy registers
      write(16'h0004, 16'h00DF, 1'b0);
      pop_one();

      // Window filter
      win_lo = 16'h0080; win_hi = 16'h00FF;
      write(16'h0081, 16'h1200, 1'b1);
      write(16'h0303, 16'h5555, 1'b0);
      write(16'h00FF, 16'h0BCD, 1'b0);
      write(16'h0100, 16'h0BCE, 1'b0);
      write(16'h007F, 16'h0BCF, 1'b0);
      pop_one();
      pop_one();

      // Empty window and disabled capture
      win_lo = 16'h0010; win_hi = 16'h0005;
      write(16'h0007, 16'hAAAA, 1'b0);
      win_lo = 16'h0000; win_hi = 16'hFFFF;
      trc_en = 1'b0;
      write(16'h0009, 16'hBBBB, 1'b1);
      trc_en = 1'b1;

      // Overflow: 6 writes into 4 entries
      for (int i = 0; i < 6; i++)
         write(16'(100 + i), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      // Push and pop while full
      step(1'b1, 1'b1, 16'h0777, 16'hCAFE, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) pop_one();
      // Pop while empty, then push+pop while empty
      pop_one();
      step(1'b1, 1'b0, 16'h0222, 16'h3333, 1'b1, 1'b0);
      pop_one();

      // Clear alongside a push with 3 entries held and a non-zero drop count
      for (int i = 0; i < 6; i++)
         write(16'(200 + i), 16'($urandom_range(0, 65535)), 1'b0);
      pop_one();
      step(1'b1, 1'b0, 16'h0444, 16'h4444, 1'b0, 1'b1);

      // Drop counter saturation
      for (int i = 0; i < 13; i++)
         write(16'(300 + i), 16'($urandom_range(0, 65535)), 1'b0);
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

      // Asynchronous reset mid-burst
      write(16'h0010, 16'h1111, 1'b0);
      write(16'h0011, 16'h2222, 1'b1);
      #2 rst = 1'b1;
      #1 model_reset();
      chk_state();
      @(negedge clk);
      rst = 1'b0;
      chk_state();

`ifdef DMEM_TRACE_TIMESTAMP_EN
      repeat (10) idle();
      write(16'h0050, 16'h5050, 1'b0);
      chk("trc_ts", trc_ts, 32'd10);
`else
      idle();
`endif
      write(16'h0060, 16'h6060, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_write_tracer.md
Name: dmem_write_tracer

Overview:
- Parametrised successor of the single-entry "last data-memory write" capture register used around the stack CPU.
- Snoops the CPU data-memory write port and records every qualifying write (address, data, byte flag) into a first-word-fall-through (FWFT) FIFO with pop handshake, address-window filter and saturating drop counter.
- Also keeps legacy last_wr_addr/last_wr_data outputs.
- Sits beside cpu in benches and FPGA debug builds; read out by a debug UART or testbench.

Parameters:
- ADDR_W, `ADDR_WIDTH, width of dmem_addr and recorded address.
- DATA_W, 16, width of dmem_wdata and recorded data.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- DROP_W, 8, width of saturating drop counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- dmem_wen  in  1  CPU data write strobe.
- dmem_byt  in  1  CPU byte-access flag.
- dmem_addr  in  ADDR_W  CPU data address.
- dmem_wdata  in  DATA_W  CPU write data.
- trc_en  in  1  capture enable.
- win_lo  in  ADDR_W  filter window lower bound, inclusive.
- win_hi  in  ADDR_W  filter window upper bound, inclusive.
- trc_clr  in  1  synchronous flush.
- trc_pop  in  1  consume head entry.
- trc_valid  out  1  FIFO non-empty.
- trc_addr  out  ADDR_W  head address.
- trc_data  out  DATA_W  head data.
- trc_byt  out  1  head byte flag.
- trc_count  out  $clog2(DEPTH)+1  entries held.
- trc_full  out  1  count == DEPTH.
- drop_cnt  out  DROP_W  writes lost to full FIFO.
- last_wr_addr  out  ADDR_W  most recent write address.
- last_wr_data  out  DATA_W  most recent write data.

Behaviour:
- Reset (async, immediate, also mid-operation):
  - pointers and count = 0; trc_valid = 0; trc_full = 0; drop_cnt = 0.
  - last_wr_addr = 0; last_wr_data = all ones (16'hFFFF).
  - trc_addr/trc_data/trc_byt = 0 while empty.
- Qualify: push_req = dmem_wen & trc_en & (win_lo <= dmem_addr <= win_hi), unsigned compare.
  - win_lo > win_hi means an empty window; nothing is captured.
- Capture: the entry is written at the posedge where push_req is sampled high. It is visible on trc_* by the next cycle (1-cycle latency).
- Data is recorded exactly as on dmem_wdata; no lane masking. trc_byt = dmem_byt.
- FWFT read:
  - trc_* always show the head entry.
  - trc_pop & trc_valid at a posedge advances the head.
  - trc_pop while empty is ignored; no underflow and no state change.
- Pointers: $clog2(DEPTH)+1 bits; wrap modulo 2*DEPTH. Full/empty are decided by the MSB comparison.
- Simultaneous events:
  - push & pop while full: both accepted; count unchanged; no drop.
  - push & pop while empty: push accepted; pop ignored; count becomes 1.
  - push while full without pop: entry discarded; drop_cnt += 1, saturating at 2^DROP_W-1.
  - trc_clr: pointers, count and drop_cnt go to 0 at the posedge. Clr beats a same-cycle push and pop; that push is lost and not counted.
- last_wr_addr/last_wr_data update on every dmem_wen, independent of trc_en, the window and trc_clr. Not cleared by trc_clr.
- No combinational path from trc_pop to trc_valid.

Optional Feature:
- DMEM_TRACE_TIMESTAMP_EN defined:
  - free-running 32-bit cycle counter, reset 0, wraps;
  - extra output trc_ts[31:0] holds the counter value sampled at the capture posedge;
  - counter unaffected by trc_clr.
- Undefined: no counter and no trc_ts port; entry width = ADDR_W+DATA_W+1.

Decomposition:
- Package dmem_trace_pkg:
  - trace_entry_t packed struct {addr, data, byt[, ts]}, with ts conditional on the macro;
  - TS_W = 32 constant.
- Sub-module sync_fifo_fwft (params WIDTH, DEPTH): owns storage, pointers, count, full/empty, clear.
- The tracer owns qualification, drop counter, last-write registers and timestamp.

Test Plan:
- Reset, then write 16'h00DF to 16'h0004 with trc_en=1, window 0..FFFF -> next cycle trc_valid=1, trc_addr=0004, trc_data=00DF, trc_byt=0; last_wr_addr=0004, last_wr_data=00DF. Before that write: last_wr_data=FFFF.
- Window 0x0080..0x00FF; writes to 0x0081 (byt=1, 0x1200) and 0x0303 -> only 0x0081 queued, trc_byt=1, trc_count=1; last_wr_addr=0303.
- With DEPTH=4: 6 writes, no pops -> trc_full=1, trc_count=4, drop_cnt=2; the 4 pops return the first 4 entries in order; then trc_valid=0.
- Full FIFO, push+pop in the same cycle -> count stays 4, drop_cnt unchanged, new entry appears last.
- trc_clr asserted alongside push with 3 entries held -> count=0, drop_cnt=0, trc_valid=0 next cycle; last_wr_* reflect that push.
- Assert rst mid-burst (2 entries queued) -> outputs go to reset values immediately, without waiting for clk. With DMEM_TRACE_TIMESTAMP_EN: a write 10 cycles after reset release gives trc_ts=10.
